edge_detect: RTL and testbench

// - Brings one asynchronous level input into the clk domain through a flop synchronizer.
// - Emits one-cycle registered pulses on its rising and falling transitions.
// - Used wherever an off-chip or other-domain strobe/level must be turned into clk-domain edge events.

---
 rtl/edge_detect_if.sv | 9 +
 rtl/edge_detect.sv | 70 +++++++
 tb/tb_edge_detect.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_if.sv
// Bus for edge_detect: the asynchronous level in, the rise/fall pulses out.
interface edge_detect_if;
  logic async_sig;
  logic rise;
  logic fall;

  modport master (output async_sig, input rise, input fall);
  modport slave  (input async_sig, output rise, output fall);
endinterface

// File: rtl/edge_detect.sv
// Synchronizes an asynchronous level into clk and emits one-cycle rise/fall pulses.
// Optional stability filter enabled by defining EDGE_DETECT_FILTER_EN.
module edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic          clk,
  input  logic          rst,
  edge_detect_if.slave  bus
);

  logic [SYNC_STAGES-1:0] s;
  logic                   level;
  logic                   prev;
  logic                   riseReg;
  logic                   fallReg;

  // Plain flop chain, nothing between stages, so metastability has full cycles to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], bus.async_sig};
    end
  end

`ifdef EDGE_DETECT_FILTER_EN
  // The newest synchronized sample plus h form a window of FILTER_LEN samples;
  // the level only moves once the whole window agrees.
  logic [FILTER_LEN-2:0] h;
  logic [FILTER_LEN-1:0] window;
  logic                  f;

  assign window = {h, s[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      f <= 1'b0;
    end else begin
      h <= window[FILTER_LEN-2:0];
      if (&window) begin
        f <= 1'b1;
      end else if (~|window) begin
        f <= 1'b0;
      end
    end
  end

  assign level = f;
`else
  assign level = s[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      riseReg <= 1'b0;
      fallReg <= 1'b0;
    end else begin
      prev    <= level;
      riseReg <= level & ~prev;
      fallReg <= ~level & prev;
    end
  end

  assign bus.rise = riseReg;
  assign bus.fall = fallReg;

endmodule

// File: tb/tb_edge_detect.sv
// Self-checking bench for edge_detect: directed per-cycle vector table plus
// hand-written reset, random-toggle and (when built with the filter) glitch sequences.
module tb_edge_detect;

`ifdef EDGE_DETECT_FILTER_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  edge_detect_if bus ();

  edge_detect #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic sig;
    logic expRise;
    logic expFall;
  } vec_t;

  vec_t vecs [25];

  // Random-toggle monitor state
  logic monitorOn;
  int   pulseCount;
  logic lastWasRise;
  logic prevRise;
  logic prevFall;

  task automatic applyStimulus(input logic r, input logic sig);
    rst           = r;
    bus.async_sig = sig;
  endtask

  task automatic checkOutput(input string name, input logic expRise, input logic expFall);
    checks++;
    if (bus.rise !== expRise || bus.fall !== expFall) begin
      errors++;
      $display("[TB] FAIL %s: rise/fall got %b%b expected %b%b at %0t",
               name, bus.rise, bus.fall, expRise, expFall, $time);
    end
  endtask

  // Over-the-run invariants while random toggling is active
  always @(negedge clk) begin
    if (monitorOn) begin
      if (bus.rise || bus.fall) begin
        checks++;
        if (bus.rise && bus.fall) begin
          errors++;
          $display("[TB] FAIL exclusive: rise/fall got 11 expected one-hot at %0t", $time);
        end else if ((bus.rise && prevRise) || (bus.fall && prevFall)) begin
          errors++;
          $display("[TB] FAIL width: pulse got >1 cycle expected 1 cycle at %0t", $time);
        end else if (bus.rise == lastWasRise) begin
          errors++;
          $display("[TB] FAIL alternate: got rise=%b twice expected alternation at %0t",
                   bus.rise, $time);
        end
        pulseCount  <= pulseCount + 1;
        lastWasRise <= bus.rise;
      end
      prevRise <= bus.rise;
      prevFall <= bus.fall;
    end
  end

  initial begin
    int toggles;
    int elapsed;
    int gap;
    logic level;

    checks      = 0;
    errors      = 0;
    monitorOn   = 1'b0;
    pulseCount  = 0;
    lastWasRise = 1'b0;
    prevRise    = 1'b0;
    prevFall    = 1'b0;

    // Row c is driven at 10c+2 ns; expected values are the outputs after posedge 10c+5.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0};

    applyStimulus(1'b1, 1'b0);

`ifndef EDGE_DETECT_FILTER_EN
    for (int c = 0; c < 25; c++) begin
      applyStimulus(vecs[c].rst, vecs[c].sig);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", c), vecs[c].expRise, vecs[c].expFall);
      #2;
    end
`else
    // Unfiltered latencies do not apply; start from a clean idle state instead.
    repeat (3) @(negedge clk);
    #2;
    applyStimulus(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    // A 2-cycle high glitch never fills the 3-sample window.
    applyStimulus(1'b0, 1'b1);
    @(negedge clk); #2;
    @(negedge clk); #2;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("glitch", 1'b0, 1'b0);
    end
    #2;
    // A 10-cycle pulse gives one rise three cycles later than unfiltered (index 6 vs 3).
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("filt_rise", (i == 3 + EXTRA), 1'b0);
    end
    #2;
    applyStimulus(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("filt_fall", 1'b0, (i == 3 + EXTRA));
    end
    #2;
`endif

    // Reset released while the input is already high: one rise on the 3rd posedge.
    applyStimulus(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_high", 1'b0, 1'b0);
    #2;
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 6 + EXTRA; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rel_high%0d", i), (i == 3 + EXTRA), 1'b0);
    end
    #2;

    // Reset asserted while fall is high drops it at once.
    applyStimulus(1'b0, 1'b0);
    for (int i = 1; i <= 2 + EXTRA; i++) begin
      @(negedge clk);
      checkOutput("pre_fall", 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    checkOutput("mid_fall", 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 6 + EXTRA; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 1'b0, 1'b0);
    end
    #2;

    // Random toggling with 50-100 ns gaps over about 1000 ns.
    toggles   = 0;
    elapsed   = 0;
    level     = 1'b0;
    monitorOn = 1'b1;
    while (elapsed < 100) begin
      gap = $urandom_range(10, 5);
      repeat (gap) @(negedge clk);
      #2;
      level = ~level;
      applyStimulus(1'b0, level);
      toggles++;
      elapsed += gap;
    end
    repeat (6 + EXTRA) @(negedge clk);
    #1;
    monitorOn = 1'b0;
    checks++;
    if (pulseCount != toggles) begin
      errors++;
      $display("[TB] FAIL pulse_count: got %0d expected %0d", pulseCount, toggles);
    end
    $display("[TB] random toggles %0d pulses %0d", toggles, pulseCount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
